// File: rtl/aibnd_txctl.sv
// AIBND pad transmit controller: OFF/PARK/ACTIVE/DRAIN sequencing, 2-word buffer, 4-bit LSB-first serializer.
// Optional underrun counter enabled by defining AIBND_TXCTL_UNDERRUN_CNT_EN.
module aibnd_txctl #(
    parameter int PARK_CYC = 4
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       itx_en,
    input  logic       iasync_mode,
    input  logic       idat_async,
    input  logic       ivalid,
    input  logic [3:0] iword,
    output logic       oready,
    output logic       otxen,
    output logic       otxdat,
    output logic [1:0] ostate,
    output logic       ounderrun,
    output logic [7:0] ounderrun_cnt
);

    typedef enum logic [1:0] {
        S_OFF    = 2'b00,
        S_PARK   = 2'b01,
        S_ACTIVE = 2'b10,
        S_DRAIN  = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] park_q, park_d;
    logic [3:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic [2:0] sh_q, sh_d;
    logic [1:0] shcnt_q, shcnt_d;
    logic       bit_q, bit_d;
    logic       txdat_q, txdat_d;
    logic       und_q, und_d;
    logic       push, pop;

    assign oready = (bcnt_q != 2'd2) && (state_q == S_PARK || state_q == S_ACTIVE) && !iasync_mode;
    assign push   = ivalid && oready;

    always_comb begin
        state_d = state_q;
        park_d  = park_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        shcnt_d = shcnt_q;
        bit_d   = bit_q;
        txdat_d = txdat_q;
        und_d   = 1'b0;
        pop     = 1'b0;

        // bit_q marks that otxdat currently carries a word bit, so the gap after it is an underrun
        if (state_q == S_ACTIVE || state_q == S_DRAIN) begin
            if (shcnt_q != 2'd0) begin
                txdat_d = sh_q[0];
                sh_d    = {1'b0, sh_q[2:1]};
                shcnt_d = shcnt_q - 2'd1;
                bit_d   = 1'b1;
            end else if (bcnt_q != 2'd0) begin
                txdat_d = buf0_q[0];
                sh_d    = buf0_q[3:1];
                shcnt_d = 2'd3;
                bit_d   = 1'b1;
                pop     = 1'b1;
            end else begin
                txdat_d = 1'b0;
                bit_d   = 1'b0;
                und_d   = bit_q && (state_q == S_ACTIVE) && itx_en;
            end
        end

        case ({push, pop})
            2'b10: begin
                if (bcnt_q == 2'd0) buf0_d = iword;
                else                buf1_d = iword;
                bcnt_d = bcnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                bcnt_d = bcnt_q - 2'd1;
            end
            2'b11: begin
                buf0_d = (bcnt_q == 2'd2) ? buf1_q : iword;
                buf1_d = iword;
            end
            default: ;
        endcase

        case (state_q)
            S_OFF: begin
                if (itx_en) begin
                    state_d = S_PARK;
                    park_d  = 4'(PARK_CYC - 1);
                end
            end
            S_PARK: begin
                if (!itx_en) begin
                    state_d = S_OFF;
                    bcnt_d  = 2'd0;
                end else if (park_q == 4'd0) begin
                    state_d = S_ACTIVE;
                end else begin
                    park_d = park_q - 4'd1;
                end
            end
            S_ACTIVE: begin
                if (!itx_en) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (shcnt_q == 2'd0 && bcnt_q == 2'd0) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase

        if (iasync_mode) begin
            state_d = S_OFF;
            bcnt_d  = 2'd0;
            shcnt_d = 2'd0;
            bit_d   = 1'b0;
            txdat_d = 1'b0;
            und_d   = 1'b0;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q <= S_OFF;
            park_q  <= 4'd0;
            buf0_q  <= 4'd0;
            buf1_q  <= 4'd0;
            bcnt_q  <= 2'd0;
            sh_q    <= 3'd0;
            shcnt_q <= 2'd0;
            bit_q   <= 1'b0;
            txdat_q <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            park_q  <= park_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            shcnt_q <= shcnt_d;
            bit_q   <= bit_d;
            txdat_q <= txdat_d;
            und_q   <= und_d;
        end
    end

    // async bypass drives the pad directly; reset overrides everything without a clock
    assign otxen     = !irst && (iasync_mode || state_q != S_OFF);
    assign otxdat    = !irst && (iasync_mode ? idat_async : txdat_q);
    assign ostate    = state_q;
    assign ounderrun = und_q && !iasync_mode;

`ifdef AIBND_TXCTL_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q;
    always_ff @(posedge iclk or posedge irst) begin
        if (irst)                          ucnt_q <= 8'd0;
        else if (und_d && ucnt_q != 8'hFF) ucnt_q <= ucnt_q + 8'd1;
    end
    assign ounderrun_cnt = ucnt_q;
`else
    assign ounderrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_aibnd_txctl.sv
// Self-checking bench for aibnd_txctl: bit-timing scoreboard plus table-driven bypass vectors.
module tb_aibnd_txctl;

    localparam int PARK_CYC = 4;

    logic       iclk, irst, itx_en, iasync_mode, idat_async, ivalid;
    logic [3:0] iword;
    logic       oready, otxen, otxdat, ounderrun;
    logic [1:0] ostate;
    logic [7:0] ounderrun_cnt;

    aibnd_txctl #(.PARK_CYC(PARK_CYC)) dut (
        .iclk(iclk), .irst(irst), .itx_en(itx_en), .iasync_mode(iasync_mode),
        .idat_async(idat_async), .ivalid(ivalid), .iword(iword), .oready(oready),
        .otxen(otxen), .otxdat(otxdat), .ostate(ostate), .ounderrun(ounderrun),
        .ounderrun_cnt(ounderrun_cnt)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct { int cyc; logic b; } sb_t;
    typedef struct {
        logic tx_en, am, da;
        logic e_txen, e_txdat, e_ready;
        logic [1:0] e_state;
    } vec_t;

    sb_t  sbq[$];
    int   acc_e[$], st_e[$];
    int   errors = 0, checks = 0;
    int   cyc = 0, nf = 0, rdy_low = 0;
    logic sb_en = 0, rdy_chk = 0, und_allow = 1, words_seen = 0, gap = 0, last_acc = 0;

    function automatic int exp_cnt(input int n);
`ifdef AIBND_TXCTL_UNDERRUN_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // one clock: inputs already applied; expected bit timing derived from the latency rules
    task automatic step();
        int st, nbuf;
        #1;
        last_acc = ivalid && oready;
        if (rdy_chk) begin
            nbuf = 0;
            foreach (acc_e[i]) if (acc_e[i] <= cyc && st_e[i] > cyc) nbuf++;
            chk("ready_model", oready, (nbuf < 2));
            if (!oready) rdy_low++;
        end
        @(posedge iclk);
        cyc++;
        gap = und_allow && words_seen && (nf == cyc);
        if (last_acc && sb_en) begin
            st = (cyc + 1 > nf) ? cyc + 1 : nf;
            for (int b = 0; b < 4; b++) sbq.push_back('{st + b, iword[b]});
            nf = st + 4;
            words_seen = 1;
            acc_e.push_back(cyc);
            st_e.push_back(st);
        end
        @(negedge iclk);
        if (sb_en) begin
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                chk("txdat_bit", otxdat, sbq[0].b);
                void'(sbq.pop_front());
            end else begin
                chk("txdat_idle", otxdat, 0);
            end
            chk("underrun", ounderrun, gap);
        end
    endtask

    task automatic sb_restart();
        sbq.delete();
        acc_e.delete();
        st_e.delete();
        words_seen = 0;
        nf = 0;
    endtask

    vec_t       vt[5];
    logic [3:0] wl[16];
    int         w;

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
        vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
        for (int i = 0; i < 16; i++) wl[i] = 4'((i * 7 + 3) % 16);

        irst = 1; itx_en = 0; iasync_mode = 0; idat_async = 0; ivalid = 0; iword = 0;
        #2;
        chk("rst_state", ostate, 0);   chk("rst_txen", otxen, 0);  chk("rst_txdat", otxdat, 0);
        chk("rst_ready", oready, 0);   chk("rst_und", ounderrun, 0); chk("rst_cnt", ounderrun_cnt, 0);
        itx_en = 1;
        @(posedge iclk); #1;
        chk("rst_hold_state", ostate, 0);
        @(negedge iclk);
        irst = 0;
        sb_en = 1;

        // reset release and PARK duration
        for (int i = 0; i < PARK_CYC; i++) begin
            step();
            chk("park_state", ostate, 1); chk("park_txen", otxen, 1);
        end
        step();
        chk("active_entry", ostate, 2);

        // two back-to-back words, then one underrun
        rdy_chk = 1;
        ivalid = 1; iword = 4'b1011; step();
        iword = 4'b0100; step();
        ivalid = 0;
        for (int i = 0; i < 12; i++) step();
        chk("sb_empty_pair", sbq.size(), 0);
        chk("cnt_after_pair", ounderrun_cnt, exp_cnt(1));

        // continuous valid with backpressure, 16 words
        w = 0;
        for (int t = 0; t < 200 && w < 16; t++) begin
            iword = wl[w]; ivalid = 1;
            step();
            if (last_acc) w++;
        end
        ivalid = 0;
        chk("stream_words", w, 16);
        for (int t = 0; t < 100 && sbq.size() > 0; t++) step();
        for (int i = 0; i < 3; i++) step();
        chk("sb_empty_stream", sbq.size(), 0);
        chk("backpressure_seen", (rdy_low > 0), 1);
        chk("cnt_after_stream", ounderrun_cnt, exp_cnt(2));
        rdy_chk = 0;

        // drop itx_en on the accepting edge; re-request during DRAIN is ignored
        und_allow = 0;
        ivalid = 1; iword = 4'b0110; itx_en = 0; step();
        chk("drain_entry", ostate, 3);
        ivalid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_state", ostate, 3); chk("drain_txen", otxen, 1);
            if (i == 1) itx_en = 1;
        end
        step();
        chk("drain_off", ostate, 0); chk("drain_txen_off", otxen, 0);
        chk("sb_empty_drain", sbq.size(), 0);
        step();
        chk("off_to_park", ostate, 1);
        for (int i = 0; i < PARK_CYC; i++) step();
        chk("reactive", ostate, 2);
        sb_restart();
        und_allow = 1;

        // async bypass mid-word
        ivalid = 1; iword = 4'b1011; step();
        iword = 4'b0100; step();
        ivalid = 0; step();
        sb_en = 0;
        iasync_mode = 1; idat_async = 1; #1;
        chk("async_dat1", otxdat, 1); chk("async_txen", otxen, 1); chk("async_ready", oready, 0);
        idat_async = 0; #1;
        chk("async_dat0", otxdat, 0);
        idat_async = 1;
        step();
        chk("async_state", ostate, 0); chk("async_und", ounderrun, 0); chk("async_follow", otxdat, 1);
        iasync_mode = 0; idat_async = 0;
        sb_restart();
        sb_en = 1;
        for (int i = 0; i < PARK_CYC + 2; i++) step();
        chk("async_reactive", ostate, 2); chk("async_flush_ready", oready, 1);
        for (int i = 0; i < 8; i++) step();
        chk("cnt_after_async", ounderrun_cnt, exp_cnt(2));

        // reset mid-word without a clock edge
        ivalid = 1; iword = 4'b1111; step();
        ivalid = 0; step();
        chk("pre_rst_txdat", otxdat, 1);
        #2 irst = 1; #1;
        chk("arst_txen", otxen, 0); chk("arst_txdat", otxdat, 0); chk("arst_ready", oready, 0);
        chk("arst_state", ostate, 0); chk("arst_cnt", ounderrun_cnt, 0);
        sb_en = 0; sb_restart();
        @(negedge iclk);
        itx_en = 0; irst = 0;

        // bypass vectors from OFF; the PARK row also checks discard on PARK exit
        for (int r = 0; r < 5; r++) begin
            itx_en = vt[r].tx_en; iasync_mode = vt[r].am; idat_async = vt[r].da; #1;
            chk("vec_txen", otxen, vt[r].e_txen);
            chk("vec_txdat", otxdat, vt[r].e_txdat);
            chk("vec_ready", oready, vt[r].e_ready);
            step();
            chk("vec_state", ostate, vt[r].e_state);
            if (vt[r].e_state == 2'b01) begin
                #1 chk("park_ready", oready, 1);
                ivalid = 1; iword = 4'b1111; step();
                ivalid = 0; itx_en = 0; step();
                chk("park_abort", ostate, 0);
            end
            itx_en = 0; iasync_mode = 0; idat_async = 0;
        end
        itx_en = 1; sb_en = 1;
        for (int i = 0; i < PARK_CYC + 1; i++) step();
        chk("discard_active", ostate, 2);
        for (int i = 0; i < 8; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
